// File: rtl/int_controller_pkg.sv
// Shared types and constants for the interrupt controller: register addresses,
// source indices, vector table and acknowledge FSM encoding.
package int_controller_pkg;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    SRC_VBLANK = 3'd0,
    SRC_LCDC   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } int_src_t;

  localparam logic [7:0] INT_VEC_VBLANK = 8'h40;
  localparam logic [7:0] INT_VEC_LCDC   = 8'h48;
  localparam logic [7:0] INT_VEC_TIMER  = 8'h50;
  localparam logic [7:0] INT_VEC_SERIAL = 8'h58;
  localparam logic [7:0] INT_VEC_JOYPAD = 8'h60;

  typedef logic [0:0] ack_state_t;
  localparam ack_state_t ACK_IDLE = 1'b0;
  localparam ack_state_t ACK_HELD = 1'b1;

  function automatic logic [7:0] int_vector(input int_src_t src);
    logic [7:0] v;
    case (src)
      SRC_VBLANK: v = INT_VEC_VBLANK;
      SRC_LCDC:   v = INT_VEC_LCDC;
      SRC_TIMER:  v = INT_VEC_TIMER;
      SRC_SERIAL: v = INT_VEC_SERIAL;
      SRC_JOYPAD: v = INT_VEC_JOYPAD;
      default:    v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_controller_priority_enc.sv
// Fixed-priority encoder over pending & enabled sources; bit 0 (vblank) wins.
// Purely combinational: one-hot clear mask, source index, valid and vector.
module int_priority_enc
  import int_controller_pkg::*;
(
  input  logic [4:0] pend,
  output logic [4:0] clr_mask,
  output int_src_t   sel,
  output logic       valid,
  output logic [7:0] vector
);

  always_comb begin
    clr_mask = 5'b00000;
    sel      = SRC_VBLANK;
    valid    = |pend;
    vector   = 8'h00;
    casez (pend)
      5'b????1: sel = SRC_VBLANK;
      5'b???10: sel = SRC_LCDC;
      5'b??100: sel = SRC_TIMER;
      5'b?1000: sel = SRC_SERIAL;
      5'b10000: sel = SRC_JOYPAD;
      default:  sel = SRC_VBLANK;
    endcase
    if (valid) begin
      clr_mask = 5'b00001 << sel;
      vector   = int_vector(sel);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Memory-mapped IF/IE interrupt controller: latches peripheral requests into IF,
// masks with IE, presents irq/vector and retires one flag per CPU acknowledge.
module int_controller
  import int_controller_pkg::*;
#(
  parameter logic [15:0] IF_ADDR  = int_controller_pkg::IF_ADDR,
  parameter logic [15:0] IE_ADDR  = int_controller_pkg::IE_ADDR,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  inout  wire  [7:0]  databus,
  input  logic        RE,
  input  logic        WE,
  input  logic        vblank_req,
  input  logic        lcdc_req,
  input  logic        timer_req,
  input  logic        serial_req,
  input  logic        joypad_req,
  output logic        vblank_int,
  output logic        lcdc_int,
  output logic        timer_int,
  output logic        serial_int,
  output logic        joypad_int,
  output logic [7:0]  int_en,
  input  logic        int_clear,
  output logic        irq,
  output logic [7:0]  irq_vector
);

  logic [4:0] req;
  logic [4:0] req_d;
  logic [4:0] rise;
  logic [4:0] if_q;
  logic [7:0] ie_q;
  logic [4:0] pend;
  logic [4:0] clr_mask;
  int_src_t   sel;
  logic       valid;
  ack_state_t state;
  logic       ack_take;
  logic       wr_if, wr_ie, rd_if, rd_ie;
  logic [7:0] rd_data;

  assign req  = {joypad_req, serial_req, timer_req, lcdc_req, vblank_req};
  assign rise = EDGE_DET ? (req & ~req_d) : req;
  assign pend = if_q & ie_q[4:0];

  int_priority_enc u_prio (
    .pend     (pend),
    .clr_mask (clr_mask),
    .sel      (sel),
    .valid    (valid),
    .vector   (irq_vector)
  );

  always_comb begin
    assert (!valid || clr_mask[sel]);
  end

  assign irq      = valid;
  // Only the first cycle of an acknowledge retires a flag; HELD absorbs long pulses.
  assign ack_take = (state == ACK_IDLE) && int_clear && valid;

  assign wr_if = WE && (addr == IF_ADDR);
  assign wr_ie = WE && (addr == IE_ADDR);
  assign rd_if = RE && !WE && !rst && (addr == IF_ADDR);
  assign rd_ie = RE && !WE && !rst && (addr == IE_ADDR);

  assign rd_data = rd_if ? {3'b111, if_q} : ie_q;
  assign databus = (rd_if || rd_ie) ? rd_data : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 5'b00000;
      if_q  <= 5'b00000;
      ie_q  <= 8'h00;
      state <= ACK_IDLE;
    end else begin
      req_d <= req;
      // A request rising in the same cycle as a write or ack always sets its bit.
      if_q  <= (wr_if ? databus[4:0] : (if_q & ~(ack_take ? clr_mask : 5'b00000))) | rise;
      if (wr_ie) ie_q <= databus;
      case (state)
        ACK_IDLE: if (int_clear)  state <= ACK_HELD;
        ACK_HELD: if (!int_clear) state <= ACK_IDLE;
        default:  state <= ACK_IDLE;
      endcase
    end
  end

  assign {joypad_int, serial_int, timer_int, lcdc_int, vblank_int} = if_q;
  assign int_en = ie_q;

endmodule

// File: tb/tb_int_controller.sv
// Randomized bench for int_controller against a register-level reference model
// of the IF/IE/acknowledge rules; undriven bus reads as 8'hFF via pull-ups.
module tb_int_controller;
  import int_controller_pkg::*;

  localparam bit EDGE = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  req = 5'b00000;
  logic        int_clear = 1'b0;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  wire  [7:0]  databus;
  logic [4:0]  ints;
  logic [7:0]  int_en;
  logic        irq;
  logic [7:0]  irq_vector;

  assign databus = tb_oe ? tb_dat : 8'hzz;
  for (genvar b = 0; b < 8; b++) begin : g_pu
    pullup (databus[b]);
  end

  always #5 clk = ~clk;

  int_controller #(.EDGE_DET(EDGE)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .databus    (databus),
    .RE         (re),
    .WE         (we),
    .vblank_req (req[0]),
    .lcdc_req   (req[1]),
    .timer_req  (req[2]),
    .serial_req (req[3]),
    .joypad_req (req[4]),
    .vblank_int (ints[0]),
    .lcdc_int   (ints[1]),
    .timer_int  (ints[2]),
    .serial_int (ints[3]),
    .joypad_int (ints[4]),
    .int_en     (int_en),
    .int_clear  (int_clear),
    .irq        (irq),
    .irq_vector (irq_vector)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference state: register contents plus "was int_clear high last edge".
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [4:0] m_req_d;
  logic       m_clear_prev;

  function automatic int lowest(input logic [4:0] v);
    int r = -1;
    for (int i = 4; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_if = 5'b0; m_ie = 8'h00; m_req_d = 5'b0; m_clear_prev = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] rise, clr, pend;
    int s;
    rise = EDGE ? (req & ~m_req_d) : req;
    pend = m_if & m_ie[4:0];
    s    = lowest(pend);
    clr  = 5'b0;
    if (int_clear && !m_clear_prev && s >= 0) clr[s] = 1'b1;
    if (we && addr == IF_ADDR) m_if = tb_dat[4:0] | rise;
    else                       m_if = (m_if & ~clr) | rise;
    if (we && addr == IE_ADDR) m_ie = tb_dat;
    m_req_d      = req;
    m_clear_prev = int_clear;
  endtask

  task automatic check_outputs();
    logic [4:0] pend;
    logic [7:0] exp_vec, exp_bus;
    int s;
    pend    = m_if & m_ie[4:0];
    s       = lowest(pend);
    exp_vec = (s >= 0) ? 8'(8'h40 + 8 * s) : 8'h00;
    if (tb_oe)                                   exp_bus = tb_dat;
    else if (re && !rst && addr == IF_ADDR)      exp_bus = {3'b111, m_if};
    else if (re && !rst && addr == IE_ADDR)      exp_bus = m_ie;
    else                                         exp_bus = 8'hFF;
    chk("ints",    16'(ints),       16'(m_if));
    chk("int_en",  16'(int_en),     16'(m_ie));
    chk("irq",     16'(irq),        16'(pend != 5'b0));
    chk("vector",  16'(irq_vector), 16'(exp_vec));
    chk("databus", 16'(databus),    16'(exp_bus));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic run_cycle();
    #1;
    if (rst) model_reset();
    check_outputs();
    if (!rst) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    re = 1'b0; we = 1'b0; tb_oe = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    re = 1'b0; we = 1'b1; tb_oe = 1'b1; addr = a; tb_dat = d;
  endtask

  task automatic bus_read(input logic [15:0] a);
    re = 1'b1; we = 1'b0; tb_oe = 1'b0; addr = a;
  endtask

  task automatic rand_inputs();
    int op;
    bus_idle();
    op = $urandom_range(0, 9);
    case (op)
      0: bus_read(IF_ADDR);
      1: bus_read(IE_ADDR);
      2: bus_read(16'($urandom_range(0, 16'hFF00)));
      3: bus_write(IF_ADDR, 8'($urandom));
      4: bus_write(IE_ADDR, 8'($urandom));
      5: bus_write(16'($urandom_range(0, 16'hFF00)), 8'($urandom));
      6: begin bus_write(IE_ADDR, 8'($urandom)); re = 1'b1; end
      default: ;
    endcase
    for (int i = 0; i < 5; i++)
      if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
    if ($urandom_range(0, 3) == 0) int_clear = ~int_clear;
    rst = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    run_cycle();
    rst = 1'b0;

    // Single timer pulse with only timer enabled.
    bus_write(IE_ADDR, 8'h04); run_cycle();
    bus_idle(); req[2] = 1'b1; run_cycle();
    req[2] = 1'b0; #1;
    chk("tp_timer_int", 16'(ints[2]), 16'h1);
    chk("tp_timer_vec", 16'(irq_vector), 16'h50);
    run_cycle();

    // Vblank + joypad pending; a long ack retires only vblank.
    bus_write(IF_ADDR, 8'h00); run_cycle();
    bus_write(IE_ADDR, 8'h1F); req[0] = 1'b1; req[4] = 1'b1; run_cycle();
    bus_idle(); req[0] = 1'b0; req[4] = 1'b0; run_cycle();
    int_clear = 1'b1;
    repeat (3) run_cycle();
    int_clear = 1'b0; run_cycle();
    chk("tp_long_ack_if", 16'(ints), 16'h10);
    chk("tp_long_ack_vec", 16'(irq_vector), 16'h60);
    int_clear = 1'b1; run_cycle();
    int_clear = 1'b0; run_cycle();
    chk("tp_second_ack_irq", 16'(irq), 16'h0);

    // Held level does not re-set the flag after software clears it.
    req[1] = 1'b1;
    repeat (4) run_cycle();
    bus_write(IF_ADDR, 8'h00); run_cycle();
    bus_idle();
    repeat (5) run_cycle();
    chk("tp_level_no_reset", 16'(ints[1]), 16'h0);
    req[1] = 1'b0; run_cycle();

    // Request rising alongside a clearing write wins.
    bus_write(IF_ADDR, 8'h00); req[3] = 1'b1; run_cycle();
    bus_read(IF_ADDR); req[3] = 1'b0; #1;
    chk("tp_write_vs_rise", 16'(databus), 16'hE8);
    run_cycle();

    // Register readback and unmapped read.
    bus_write(IE_ADDR, 8'hA5); run_cycle();
    bus_read(IE_ADDR); run_cycle();
    bus_write(IF_ADDR, 8'h03); run_cycle();
    bus_read(IF_ADDR); #1;
    chk("tp_read_if", 16'(databus), 16'hE3);
    run_cycle();
    bus_read(16'h1234); run_cycle();

    // Reset while an acknowledge is held, then int_clear stays high.
    bus_write(IF_ADDR, 8'h1F); run_cycle();
    bus_write(IE_ADDR, 8'h1F); run_cycle();
    bus_idle(); int_clear = 1'b1; run_cycle();
    run_cycle();
    rst = 1'b1; run_cycle();
    rst = 1'b0; run_cycle();
    bus_write(IE_ADDR, 8'h1F); req[2] = 1'b1; run_cycle();
    bus_idle(); req[2] = 1'b0; int_clear = 1'b0; run_cycle();
    int_clear = 1'b1; run_cycle();
    run_cycle();
    chk("tp_post_reset_ack", 16'(ints[2]), 16'h0);
    int_clear = 1'b0; run_cycle();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      run_cycle();
    end
    rst = 1'b0;
    bus_idle();
    run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
